// File: rtl/sd_card_sec_ctrl.sv
// SPI-mode SD card sequencer: power-up, CMD0/CMD8/ACMD41 init, then
// single-sector CMD17/CMD24 transfers through the sd_card_cmd engine.
module sd_card_sec_ctrl #(
   parameter int PWR_UP_CYCLES = 5000,
   parameter int CMD0_RETRY    = 8,
   parameter int ACMD41_RETRY  = 1023
) (
   input  logic        sys_clk,
   input  logic        rst,
   output logic        cmd_req,
   input  logic        cmd_req_ack,
   input  logic        cmd_req_error,
   output logic [47:0] cmd,
   output logic [7:0]  cmd_r1,
   output logic [15:0] cmd_data_len,
   output logic        block_read_req,
   input  logic        block_read_req_ack,
   output logic        block_write_req,
   input  logic        block_write_req_ack,
   input  logic        sd_sec_read,
   input  logic [31:0] sd_sec_read_addr,
   output logic        sd_sec_read_end,
   input  logic        sd_sec_write,
   input  logic [31:0] sd_sec_write_addr,
   output logic        sd_sec_write_end,
   output logic        sd_init_done,
   output logic        sd_busy,
   output logic        sd_error
);

   localparam int PW   = (PWR_UP_CYCLES > 1) ? $clog2(PWR_UP_CYCLES) : 1;
   localparam int C0W  = $clog2(CMD0_RETRY + 1);
   localparam int A41W = $clog2(ACMD41_RETRY + 1);

   typedef enum logic [3:0] {
      S_PWR,
      S_CMD0,
      S_CMD8,
      S_CMD55,
      S_ACMD41,
      S_READY,
      S_RD_CMD,
      S_RD_DATA,
      S_RD_END,
      S_WR_CMD,
      S_WR_DATA,
      S_WR_END,
      S_ERR
   } state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    pwr_cnt, pwr_cnt_nxt;
   logic [C0W-1:0]   cmd0_cnt, cmd0_cnt_nxt;
   logic [A41W-1:0]  a41_cnt, a41_cnt_nxt;
   logic [31:0]      addr, addr_nxt;
   logic [47:0]      cmd_nxt;
   logic [7:0]       cmd_r1_nxt;
   logic [15:0]      cmd_data_len_nxt;
   logic             cmd_req_nxt;
   logic             block_read_req_nxt;
   logic             block_write_req_nxt;
   logic             rd_end_nxt;
   logic             wr_end_nxt;
   logic             init_done_nxt;
   logic             busy_nxt;
   logic             error_nxt;

   logic cmd_ack;
   logic cmd_ok;
   logic cmd_bad;
   logic rd_ack;
   logic wr_ack;

   // acks only count while the matching request is actually up
   assign cmd_ack = cmd_req & cmd_req_ack;
   assign cmd_ok  = cmd_ack & ~cmd_req_error;
   assign cmd_bad = cmd_ack & cmd_req_error;
   assign rd_ack  = block_read_req & block_read_req_ack;
   assign wr_ack  = block_write_req & block_write_req_ack;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state           <= S_PWR;
         pwr_cnt         <= '0;
         cmd0_cnt        <= '0;
         a41_cnt         <= '0;
         addr            <= '0;
         cmd             <= '0;
         cmd_r1          <= '0;
         cmd_data_len    <= '0;
         cmd_req         <= 1'b0;
         block_read_req  <= 1'b0;
         block_write_req <= 1'b0;
         sd_sec_read_end <= 1'b0;
         sd_sec_write_end <= 1'b0;
         sd_init_done    <= 1'b0;
         sd_busy         <= 1'b1;
         sd_error        <= 1'b0;
      end else begin
         state           <= state_nxt;
         pwr_cnt         <= pwr_cnt_nxt;
         cmd0_cnt        <= cmd0_cnt_nxt;
         a41_cnt         <= a41_cnt_nxt;
         addr            <= addr_nxt;
         cmd             <= cmd_nxt;
         cmd_r1          <= cmd_r1_nxt;
         cmd_data_len    <= cmd_data_len_nxt;
         cmd_req         <= cmd_req_nxt;
         block_read_req  <= block_read_req_nxt;
         block_write_req <= block_write_req_nxt;
         sd_sec_read_end <= rd_end_nxt;
         sd_sec_write_end <= wr_end_nxt;
         sd_init_done    <= init_done_nxt;
         sd_busy         <= busy_nxt;
         sd_error        <= error_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pwr_cnt_nxt  = pwr_cnt;
      cmd0_cnt_nxt = cmd0_cnt;
      a41_cnt_nxt  = a41_cnt;
      addr_nxt     = addr;
      unique case (state)
         S_PWR: begin
            if (pwr_cnt == PW'(PWR_UP_CYCLES - 1))
               state_nxt = S_CMD0;
            else
               pwr_cnt_nxt = pwr_cnt + 1'b1;
         end
         S_CMD0: begin
            if (cmd_ok) begin
               state_nxt = S_CMD8;
            end else if (cmd_bad) begin
               if (cmd0_cnt != C0W'(CMD0_RETRY))
                  cmd0_cnt_nxt = cmd0_cnt + 1'b1;
               if (cmd0_cnt_nxt == C0W'(CMD0_RETRY))
                  state_nxt = S_ERR;
            end
         end
         S_CMD8: begin
            if (cmd_ok)
               state_nxt = S_CMD55;
            else if (cmd_bad)
               state_nxt = S_ERR;
         end
         S_CMD55: begin
            if (cmd_ok)
               state_nxt = S_ACMD41;
            else if (cmd_bad)
               state_nxt = S_ERR;
         end
         S_ACMD41: begin
            if (cmd_ok) begin
               state_nxt = S_READY;
            end else if (cmd_bad) begin
               if (a41_cnt != A41W'(ACMD41_RETRY))
                  a41_cnt_nxt = a41_cnt + 1'b1;
               if (a41_cnt_nxt == A41W'(ACMD41_RETRY))
                  state_nxt = S_ERR;
               else
                  state_nxt = S_CMD55;
            end
         end
         S_READY: begin
            if (sd_sec_read) begin
               addr_nxt  = sd_sec_read_addr;
               state_nxt = S_RD_CMD;
            end else if (sd_sec_write) begin
               addr_nxt  = sd_sec_write_addr;
               state_nxt = S_WR_CMD;
            end
         end
         S_RD_CMD: begin
            if (cmd_ok)
               state_nxt = S_RD_DATA;
            else if (cmd_bad)
               state_nxt = S_READY;
         end
         S_RD_DATA: begin
            if (rd_ack)
               state_nxt = S_RD_END;
         end
         S_RD_END: state_nxt = S_READY;
         S_WR_CMD: begin
            if (cmd_ok)
               state_nxt = S_WR_DATA;
            else if (cmd_bad)
               state_nxt = S_READY;
         end
         S_WR_DATA: begin
            if (wr_ack)
               state_nxt = S_WR_END;
         end
         S_WR_END: state_nxt = S_READY;
         S_ERR:    state_nxt = S_ERR;
         default:  state_nxt = S_PWR;
      endcase
   end

   // outputs are registered from the next state so they line up with entry
   always_comb begin
      cmd_nxt          = cmd;
      cmd_r1_nxt       = cmd_r1;
      cmd_data_len_nxt = cmd_data_len;
      cmd_req_nxt      = 1'b0;
      case (state_nxt)
         S_CMD0: begin
            cmd_nxt          = {8'h00, 32'h0000_0000, 8'h95};
            cmd_r1_nxt       = 8'h01;
            cmd_data_len_nxt = 16'd0;
            cmd_req_nxt      = ~cmd_ack;
         end
         S_CMD8: begin
            cmd_nxt          = {8'h08, 32'h0000_01AA, 8'h87};
            cmd_r1_nxt       = 8'h01;
            cmd_data_len_nxt = 16'd4;
            cmd_req_nxt      = ~cmd_ack;
         end
         S_CMD55: begin
            cmd_nxt          = {8'h37, 32'h0000_0000, 8'hFF};
            cmd_r1_nxt       = 8'h01;
            cmd_data_len_nxt = 16'd0;
            cmd_req_nxt      = ~cmd_ack;
         end
         S_ACMD41: begin
            cmd_nxt          = {8'h29, 32'h4000_0000, 8'hFF};
            cmd_r1_nxt       = 8'h00;
            cmd_data_len_nxt = 16'd0;
            cmd_req_nxt      = ~cmd_ack;
         end
         S_RD_CMD: begin
            cmd_nxt          = {8'h11, addr_nxt, 8'hFF};
            cmd_r1_nxt       = 8'h00;
            cmd_data_len_nxt = 16'd0;
            cmd_req_nxt      = ~cmd_ack;
         end
         S_WR_CMD: begin
            cmd_nxt          = {8'h18, addr_nxt, 8'hFF};
            cmd_r1_nxt       = 8'h00;
            cmd_data_len_nxt = 16'd0;
            cmd_req_nxt      = ~cmd_ack;
         end
         default: ;
      endcase
      block_read_req_nxt  = (state_nxt == S_RD_DATA);
      block_write_req_nxt = (state_nxt == S_WR_DATA);
      rd_end_nxt          = (state_nxt == S_RD_END);
      wr_end_nxt          = (state_nxt == S_WR_END);
      init_done_nxt       = (state_nxt == S_READY)   ||
                            (state_nxt == S_RD_CMD)  ||
                            (state_nxt == S_RD_DATA) ||
                            (state_nxt == S_RD_END)  ||
                            (state_nxt == S_WR_CMD)  ||
                            (state_nxt == S_WR_DATA) ||
                            (state_nxt == S_WR_END);
      busy_nxt            = (state_nxt != S_READY);
      error_nxt           = sd_error | (state_nxt == S_ERR);
   end

endmodule

// File: tb/tb_sd_card_sec_ctrl.sv
// Bench for sd_card_sec_ctrl: behavioural command engine plus a
// command-list reference model driven by random sector traffic.
module tb_sd_card_sec_ctrl;

   localparam int PWR  = 16;
   localparam int C0R  = 8;
   localparam int A41R = 5;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_req;
   logic        cmd_req_ack = 1'b0;
   logic        cmd_req_error = 1'b0;
   logic [47:0] cmd;
   logic [7:0]  cmd_r1;
   logic [15:0] cmd_data_len;
   logic        block_read_req;
   logic        block_read_req_ack = 1'b0;
   logic        block_write_req;
   logic        block_write_req_ack = 1'b0;
   logic        sd_sec_read = 1'b0;
   logic [31:0] sd_sec_read_addr = '0;
   logic        sd_sec_read_end;
   logic        sd_sec_write = 1'b0;
   logic [31:0] sd_sec_write_addr = '0;
   logic        sd_sec_write_end;
   logic        sd_init_done;
   logic        sd_busy;
   logic        sd_error;

   always #5 sys_clk = ~sys_clk;

   sd_card_sec_ctrl #(
      .PWR_UP_CYCLES(PWR),
      .CMD0_RETRY   (C0R),
      .ACMD41_RETRY (A41R)
   ) dut (
      .sys_clk            (sys_clk),
      .rst                (rst),
      .cmd_req            (cmd_req),
      .cmd_req_ack        (cmd_req_ack),
      .cmd_req_error      (cmd_req_error),
      .cmd                (cmd),
      .cmd_r1             (cmd_r1),
      .cmd_data_len       (cmd_data_len),
      .block_read_req     (block_read_req),
      .block_read_req_ack (block_read_req_ack),
      .block_write_req    (block_write_req),
      .block_write_req_ack(block_write_req_ack),
      .sd_sec_read        (sd_sec_read),
      .sd_sec_read_addr   (sd_sec_read_addr),
      .sd_sec_read_end    (sd_sec_read_end),
      .sd_sec_write       (sd_sec_write),
      .sd_sec_write_addr  (sd_sec_write_addr),
      .sd_sec_write_end   (sd_sec_write_end),
      .sd_init_done       (sd_init_done),
      .sd_busy            (sd_busy),
      .sd_error           (sd_error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // engine behaviour knobs and observation logs
   bit          e_cmd0 = 0;
   bit          e_rd = 0;
   bit          e_wr = 0;
   bit          blk_hold = 0;
   int          acmd_left = 0;
   logic [47:0] cmd_q[$];
   logic [7:0]  r1_q[$];
   logic [15:0] len_q[$];
   logic [47:0] exp_q[$];
   int          n_blk_rd = 0;
   int          n_blk_wr = 0;
   int          n_rd_end = 0;
   int          n_wr_end = 0;
   int          n_pulse_bad = 0;
   int          n_unstable = 0;

   initial begin : engine
      int cw, ct, bw, bt, ww, wt;
      logic [47:0] cur;
      cw = 0; ct = 1; bw = 0; bt = 1; ww = 0; wt = 1; cur = '0;
      forever begin
         @(posedge sys_clk);
         #1;
         cmd_req_ack = 1'b0;
         cmd_req_error = 1'b0;
         block_read_req_ack = 1'b0;
         block_write_req_ack = 1'b0;
         if (rst) begin
            cw = 0; bw = 0; ww = 0;
         end else begin
            if (cmd_req) begin
               if (cw == 0) begin
                  cur = cmd;
                  cmd_q.push_back(cmd);
                  r1_q.push_back(cmd_r1);
                  len_q.push_back(cmd_data_len);
                  ct = $urandom_range(1, 3);
               end else if (cmd !== cur) begin
                  n_unstable++;
               end
               cw++;
               if (cw >= ct) begin
                  cmd_req_ack = 1'b1;
                  cw = 0;
                  if (cmd[47:40] == 8'h00)
                     cmd_req_error = e_cmd0;
                  else if (cmd[47:40] == 8'h29 && acmd_left > 0) begin
                     cmd_req_error = 1'b1;
                     acmd_left--;
                  end else if (cmd[47:40] == 8'h11)
                     cmd_req_error = e_rd;
                  else if (cmd[47:40] == 8'h18)
                     cmd_req_error = e_wr;
               end
            end
            if (block_read_req && !blk_hold) begin
               if (bw == 0) begin
                  n_blk_rd++;
                  bt = $urandom_range(1, 4);
               end
               bw++;
               if (bw >= bt) begin
                  block_read_req_ack = 1'b1;
                  bw = 0;
               end
            end
            if (block_write_req) begin
               if (ww == 0) begin
                  n_blk_wr++;
                  wt = $urandom_range(1, 4);
               end
               ww++;
               if (ww >= wt) begin
                  block_write_req_ack = 1'b1;
                  ww = 0;
               end
            end
         end
      end
   end

   bit prev_re = 0;
   bit prev_we = 0;
   always @(negedge sys_clk) begin
      if (sd_sec_read_end) n_rd_end++;
      if (sd_sec_write_end) n_wr_end++;
      if ((sd_sec_read_end && prev_re) || (sd_sec_write_end && prev_we))
         n_pulse_bad++;
      prev_re = sd_sec_read_end;
      prev_we = sd_sec_write_end;
   end

   // expected R1 / trailing length straight from the command table
   function automatic logic [7:0] exp_r1(input logic [7:0] idx);
      return (idx == 8'h00 || idx == 8'h08 || idx == 8'h37) ? 8'h01 : 8'h00;
   endfunction

   function automatic logic [15:0] exp_len(input logic [7:0] idx);
      return (idx == 8'h08) ? 16'd4 : 16'd0;
   endfunction

   task automatic cmp_log(input string tag);
      check({tag, "_ncmd"}, 64'(cmd_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++) begin
         check({tag, "_cmd"}, 64'(cmd_q[i]), 64'(exp_q[i]));
         check({tag, "_r1"}, 64'(r1_q[i]), 64'(exp_r1(exp_q[i][47:40])));
         check({tag, "_len"}, 64'(len_q[i]), 64'(exp_len(exp_q[i][47:40])));
      end
   endtask

   task automatic clear_logs();
      cmd_q.delete(); r1_q.delete(); len_q.delete(); exp_q.delete();
      n_blk_rd = 0; n_blk_wr = 0; n_rd_end = 0; n_wr_end = 0;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      rst = 1'b1;
      sd_sec_read = 1'b0;
      sd_sec_write = 1'b0;
      repeat (2) @(negedge sys_clk);
      clear_logs();
      check("rst_cmd_req", 64'(cmd_req), 64'd0);
      check("rst_cmd", 64'(cmd), 64'd0);
      check("rst_r1_len", 64'({cmd_r1, cmd_data_len}), 64'd0);
      check("rst_blk", 64'({block_read_req, block_write_req}), 64'd0);
      check("rst_end", 64'({sd_sec_read_end, sd_sec_write_end}), 64'd0);
      check("rst_flags", 64'({sd_init_done, sd_busy, sd_error}), 64'b010);
      rst = 1'b0;
   endtask

   task automatic run_init(input int acmd_errs);
      int n;
      e_cmd0 = 0;
      acmd_left = acmd_errs;
      do_reset();
      exp_q.push_back({8'h00, 32'h0, 8'h95});
      exp_q.push_back({8'h08, 32'h1AA, 8'h87});
      for (int r = 0; r <= acmd_errs; r++) begin
         exp_q.push_back({8'h37, 32'h0, 8'hFF});
         exp_q.push_back({8'h29, 32'h4000_0000, 8'hFF});
      end
      n = 0;
      while (!sd_init_done && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      check("init_timeout", 64'(n < 3000), 64'd1);
      repeat (2) @(negedge sys_clk);
      cmp_log("init");
      check("init_flags", 64'({sd_init_done, sd_busy, sd_error}), 64'b100);
   endtask

   task automatic run_sector(input bit rd, input bit wr,
                             input logic [31:0] ra, input logic [31:0] wa,
                             input bit er, input bit ew);
      int n;
      int ncmd;
      clear_logs();
      e_rd = er;
      e_wr = ew;
      if (rd) exp_q.push_back({8'h11, ra, 8'hFF});
      if (wr) exp_q.push_back({8'h18, wa, 8'hFF});
      ncmd = int'(rd) + int'(wr);
      @(negedge sys_clk);
      sd_sec_read = rd;
      sd_sec_read_addr = ra;
      sd_sec_write = wr;
      sd_sec_write_addr = wa;
      n = 0;
      while (cmd_q.size() < 1 && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      sd_sec_read = 1'b0;
      sd_sec_read_addr = $urandom;
      while (cmd_q.size() < ncmd && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      sd_sec_write = 1'b0;
      sd_sec_write_addr = $urandom;
      while (sd_busy && n < 600) begin
         @(negedge sys_clk);
         n++;
      end
      check("sec_timeout", 64'(n < 600), 64'd1);
      repeat (3) @(negedge sys_clk);
      cmp_log("sec");
      check("sec_blk_rd", 64'(n_blk_rd), 64'(rd && !er));
      check("sec_rd_end", 64'(n_rd_end), 64'(rd && !er));
      check("sec_blk_wr", 64'(n_blk_wr), 64'(wr && !ew));
      check("sec_wr_end", 64'(n_wr_end), 64'(wr && !ew));
      check("sec_flags", 64'({sd_init_done, sd_busy, sd_error}), 64'b100);
   endtask

   initial begin : main
      int n;
      logic [31:0] a;
      run_init(2);

      run_sector(1, 0, 32'h0000_1234, 32'h0, 0, 0);
      run_sector(1, 1, $urandom, $urandom, 0, 0);
      run_sector(0, 1, 32'h0, $urandom, 0, 1);
      for (int t = 0; t < 20; t++) begin
         int op;
         op = $urandom_range(0, 2);
         run_sector(op != 1, op != 0, $urandom, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end

      // reset in the middle of a block read
      clear_logs();
      blk_hold = 1;
      e_rd = 0;
      a = $urandom;
      @(negedge sys_clk);
      sd_sec_read = 1'b1;
      sd_sec_read_addr = a;
      n = 0;
      while (!block_read_req && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      check("rdd_timeout", 64'(n < 200), 64'd1);
      sd_sec_read = 1'b0;
      check("rdd_cmd", 64'(cmd), 64'({8'h11, a, 8'hFF}));
      rst = 1'b1;
      @(negedge sys_clk);
      check("rdd_rst_req", 64'({cmd_req, block_read_req, block_write_req}), 64'd0);
      check("rdd_rst_cmd", 64'({cmd, cmd_r1, cmd_data_len}), 64'd0);
      check("rdd_rst_flags", 64'({sd_init_done, sd_busy, sd_error}), 64'b010);
      blk_hold = 0;

      run_init($urandom_range(0, 3));
      run_sector(1, 1, $urandom, $urandom, 0, 0);

      // CMD0 never answered correctly
      e_cmd0 = 1;
      do_reset();
      for (int i = 0; i < C0R; i++) exp_q.push_back({8'h00, 32'h0, 8'h95});
      n = 0;
      while (!sd_error && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      check("c0_timeout", 64'(n < 3000), 64'd1);
      repeat (50) @(negedge sys_clk);
      cmp_log("c0");
      check("c0_flags", 64'({sd_init_done, sd_busy, sd_error}), 64'b011);
      check("c0_req", 64'(cmd_req), 64'd0);

      // ACMD41 never leaves idle
      e_cmd0 = 0;
      acmd_left = 1000;
      do_reset();
      acmd_left = 1000;
      exp_q.push_back({8'h00, 32'h0, 8'h95});
      exp_q.push_back({8'h08, 32'h1AA, 8'h87});
      for (int r = 0; r < A41R; r++) begin
         exp_q.push_back({8'h37, 32'h0, 8'hFF});
         exp_q.push_back({8'h29, 32'h4000_0000, 8'hFF});
      end
      n = 0;
      while (!sd_error && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      check("a41_timeout", 64'(n < 3000), 64'd1);
      repeat (30) @(negedge sys_clk);
      cmp_log("a41");
      check("a41_flags", 64'({sd_init_done, sd_busy, sd_error}), 64'b011);

      check("end_pulse_width", 64'(n_pulse_bad), 64'd0);
      check("cmd_stable", 64'(n_unstable), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
